// File: rtl/ws2812_zone_tx_pkg.sv
// Shared timing defaults, TX state encoding and colour reorder helper for the WS2812 zone
// transmitter.
package ws2812_zone_tx_pkg;

  localparam int unsigned DefNumLed      = 45;
  localparam int unsigned DefTBit        = 186;
  localparam int unsigned DefT0H         = 59;
  localparam int unsigned DefT1H         = 119;
  localparam int unsigned DefResetCycles = 8910;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StBit,
    StLatch
  } tx_state_e;

  // Zone words arrive as {R,G,B}; the strip expects green first.
  function automatic logic [23:0] grb_reorder(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

endpackage

// File: rtl/ws2812_zone_tx_pingpong_buf.sv
// Two-bank zone colour store: one write port, one read port with a 1-clk registered read.
// All storage updates on the falling clock edge, matching the pixel pipeline.
module ws2812_zone_tx_pingpong_buf #(
  parameter int unsigned Aw = 6
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic          wr_bank_i,
  input  logic [Aw-1:0] wr_addr_i,
  input  logic [23:0]   wr_data_i,
  input  logic          rd_bank_i,
  input  logic [Aw-1:0] rd_addr_i,
  output logic [23:0]   rd_data_o
);

  // Banks are sized to the full address range so any pointer value indexes safely.
  localparam int unsigned Depth = 2 ** Aw;

  logic [23:0] mem_q [2][Depth];
  logic [23:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = mem_q[rd_bank_i][rd_addr_i];
    // Forward a same-clock write so a just-completed bank can be read immediately.
    if (wr_en_i && (wr_bank_i == rd_bank_i) && (wr_addr_i == rd_addr_i)) begin
      rd_data_d = wr_data_i;
    end
  end

  always_ff @(negedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ws2812_zone_tx.sv
// Collects one frame of zone colours into a ping-pong buffer and serialises it to a WS2812
// strip as GRB, MSB-first NRZ bits followed by a latch gap.
module ws2812_zone_tx
  import ws2812_zone_tx_pkg::*;
#(
  parameter int unsigned NumLed      = DefNumLed,
  parameter int unsigned TBit        = DefTBit,
  parameter int unsigned T0H         = DefT0H,
  parameter int unsigned T1H         = DefT1H,
  parameter int unsigned ResetCycles = DefResetCycles
) (
  input  logic        clkn,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        dv_RGB_in,
  input  logic [23:0] RGB_in,
  output logic        led_dout,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_drop
);

  localparam int unsigned Aw = $clog2(NumLed + 1);

  localparam logic [Aw-1:0] LastLed   = Aw'(NumLed - 1);
  localparam logic [Aw-1:0] FullCnt   = Aw'(NumLed);
  localparam logic [7:0]    BitLast   = 8'(TBit - 1);
  localparam logic [7:0]    Thr0      = 8'(T0H);
  localparam logic [7:0]    Thr1      = 8'(T1H);
  localparam logic [13:0]   LatchLast = 14'(ResetCycles - 1);

  tx_state_e     state_q, state_d;
  logic [23:0]   shift_q, shift_d;
  logic [7:0]    bit_cnt_q, bit_cnt_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [Aw-1:0] led_idx_q, led_idx_d;
  logic [13:0]   latch_cnt_q, latch_cnt_d;
  logic [Aw-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic          pending_q, pending_d;
  logic          led_dout_q, led_dout_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_drop_q, frame_drop_d;

  logic          wr_adv, wr_full, wr_en, swap;
  logic [Aw-1:0] rd_addr;
  logic [23:0]   rd_data;

  // Write side and bank control.
  always_comb begin
    wr_adv       = dv_RGB_in && !frame_start && (wr_cnt_q != FullCnt);
    wr_full      = wr_adv && (wr_cnt_q == LastLed);
    wr_en        = wr_adv && !pending_q;
    swap         = (state_q == StIdle) && (pending_q || wr_full);
    wr_cnt_d     = wr_cnt_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    pending_d    = pending_q;
    frame_drop_d = wr_full && pending_q;

    if (wr_adv) begin
      wr_cnt_d = wr_cnt_q + Aw'(1);
    end
    // Words counted while frozen were never stored; skip the rest of that frame.
    if (swap && pending_q && ((wr_cnt_q != '0) || wr_adv)) begin
      wr_cnt_d = FullCnt;
    end
    if (frame_start) begin
      wr_cnt_d = '0;
    end

    if (swap) begin
      rd_bank_d = wr_bank_q;
      wr_bank_d = ~wr_bank_q;
      pending_d = 1'b0;
    end else if (wr_full && !pending_q) begin
      pending_d = 1'b1;
    end
  end

  // TX FSM. The next LED word is prefetched so the reload fits in the last clock of a bit.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    led_idx_d   = led_idx_q;
    latch_cnt_d = latch_cnt_q;
    rd_addr     = led_idx_q + Aw'(1);

    unique case (state_q)
      StIdle: begin
        rd_addr = '0;
        if (swap) begin
          state_d   = StLoad;
          led_idx_d = '0;
        end
      end
      StLoad: begin
        shift_d   = grb_reorder(rd_data);
        bit_idx_d = 5'd23;
        bit_cnt_d = '0;
        state_d   = StBit;
      end
      StBit: begin
        if (bit_cnt_q == BitLast) begin
          bit_cnt_d = '0;
          if (bit_idx_q == '0) begin
            if (led_idx_q == LastLed) begin
              state_d     = StLatch;
              latch_cnt_d = '0;
            end else begin
              shift_d   = grb_reorder(rd_data);
              bit_idx_d = 5'd23;
              led_idx_d = led_idx_q + Aw'(1);
            end
          end else begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_idx_d = bit_idx_q - 5'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
      end
      StLatch: begin
        if (latch_cnt_q == LatchLast) begin
          state_d = StIdle;
        end else begin
          latch_cnt_d = latch_cnt_q + 14'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    led_dout_d   = (state_q == StBit) && (bit_cnt_q < (shift_q[23] ? Thr1 : Thr0));
    busy_d       = (state_q == StBit) || (state_q == StLatch);
    frame_done_d = (state_q == StLatch) && (latch_cnt_q == LatchLast);
  end

  always_ff @(negedge clkn or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      led_idx_q    <= '0;
      latch_cnt_q  <= '0;
      wr_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      pending_q    <= 1'b0;
      led_dout_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      led_idx_q    <= led_idx_d;
      latch_cnt_q  <= latch_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      pending_q    <= pending_d;
      led_dout_q   <= led_dout_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  ws2812_zone_tx_pingpong_buf #(
    .Aw (Aw)
  ) u_buf (
    .clk_i     (clkn),
    .wr_en_i   (wr_en),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_cnt_q),
    .wr_data_i (RGB_in),
    .rd_bank_i (rd_bank_d),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign led_dout   = led_dout_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_drop = frame_drop_q;

endmodule

// File: tb/tb_ws2812_zone_tx.sv
// Scoreboard bench: the driver queues expected GRB words, a monitor decodes the serial line.
module tb_ws2812_zone_tx;

  logic        clkn;
  logic        reset;
  logic        frame_start;
  logic        dv;
  logic [23:0] rgb;
  logic        led_dout, busy, frame_done, frame_drop;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];

  // monitor state
  int          smp = 0, since_rise = 0, hi_len = 0, nbits = 0, leds = 0, t_first = 0;
  int          busy_run = 0, rise_cnt = 0, done_cnt = 0, drop_cnt = 0;
  logic        prev_led = 1'b0;
  logic        in_frame = 1'b0;
  logic [31:0] acc = '0;

  ws2812_zone_tx #(
    .NumLed      (2),
    .TBit        (10),
    .T0H         (3),
    .T1H         (7),
    .ResetCycles (20)
  ) dut (
    .clkn        (clkn),
    .reset       (reset),
    .frame_start (frame_start),
    .dv_RGB_in   (dv),
    .RGB_in      (rgb),
    .led_dout    (led_dout),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_drop  (frame_drop)
  );

  initial clkn = 1'b1;
  always #5 clkn = ~clkn;

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Called on a rising edge; holds inputs across the next falling (active) edge.
  task automatic cyc(input logic fs, input logic v, input logic [23:0] w);
    frame_start = fs;
    dv          = v;
    rgb         = w;
    @(posedge clkn);
    frame_start = 1'b0;
    dv          = 1'b0;
    rgb         = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clkn);
  endtask

  task automatic wait_done(input int bound, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clkn);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Monitor: sampled on rising edges, half a cycle away from the DUT's falling edge.
  always @(posedge clkn) begin
    if (reset) begin
      prev_led   = 1'b0;
      in_frame   = 1'b0;
      hi_len     = 0;
      nbits      = 0;
      leds       = 0;
      busy_run   = 0;
      since_rise = 0;
    end else begin
      smp++;
      if (led_dout && !prev_led) begin
        rise_cnt++;
        if (in_frame) begin
          check("bit_period", since_rise, 10);
        end else begin
          in_frame = 1'b1;
          t_first  = smp;
          leds     = 0;
        end
        since_rise = 0;
        hi_len     = 0;
      end
      if (led_dout) hi_len++;
      if (!led_dout && prev_led) begin
        total++;
        if (hi_len == 7) begin
          acc = {8'h00, acc[22:0], 1'b1};
        end else if (hi_len == 3) begin
          acc = {8'h00, acc[22:0], 1'b0};
        end else begin
          bad++;
          $display("FAIL bit_high_width: got %0d clocks required 3 or 7", hi_len);
          acc = {8'h00, acc[22:0], 1'b0};
        end
        nbits++;
        if (nbits == 24) begin
          nbits = 0;
          leds++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL led_word: got %06h required nothing", acc);
          end else begin
            check("led_word", acc, exp_q.pop_front());
          end
        end
      end
      since_rise++;
      if (busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        check("busy_len", busy_run, 500);
        busy_run = 0;
      end
      if (frame_done) begin
        done_cnt++;
        check("frame_len", smp - t_first, 499);
        check("frame_leds", leds, 2);
        check("frame_partial_bits", nbits, 0);
        in_frame = 1'b0;
      end
      if (frame_drop) drop_cnt++;
      prev_led = led_dout;
    end
  end

  initial begin
    logic seen;
    int   d0, r0;
    reset       = 1'b1;
    frame_start = 1'b0;
    dv          = 1'b0;
    rgb         = '0;
    idle(3);
    check("rst_led", led_dout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_drop", frame_drop, 0);
    #2 reset = 1'b0;
    @(posedge clkn);

    // 1: reset while the line is high mid-bit
    cyc(1, 0, 0);
    cyc(0, 1, 24'h123456);
    cyc(0, 1, 24'h654321);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (led_dout) begin
        seen = 1'b1;
        break;
      end
      @(posedge clkn);
    end
    check("t1_started", seen, 1);
    #2 reset = 1'b1;
    #1;
    check("t1_led_low", led_dout, 0);
    check("t1_busy_low", busy, 0);
    idle(2);
    #2 reset = 1'b0;
    @(posedge clkn);
    #1 d0 = done_cnt;
    r0 = rise_cnt;
    idle(600);
    #1;
    check("t1_no_done", done_cnt - d0, 0);
    check("t1_no_bits", rise_cnt - r0, 0);
    @(posedge clkn);

    // 2: basic frame, latency and single frame_done
    #1 d0 = done_cnt;
    @(posedge clkn);
    exp_q.push_back(32'h00FF00);
    exp_q.push_back(32'h0000FF);
    cyc(1, 0, 0);
    cyc(0, 1, 24'hFF0000);
    cyc(0, 1, 24'h0000FF);
    @(posedge clkn);
    check("t2_lat_n1", led_dout, 0);
    @(posedge clkn);
    check("t2_lat_n2", led_dout, 1);
    check("t2_busy_n2", busy, 1);
    wait_done(600, seen);
    check("t2_done", seen, 1);
    idle(30);
    #1 check("t2_done_once", done_cnt - d0, 1);
    @(posedge clkn);

    // 3: second frame during TX becomes pending and starts on the first idle clock
    exp_q.push_back(32'hB2A1C3);
    exp_q.push_back(32'h1E0F2D);
    exp_q.push_back(32'h221133);
    exp_q.push_back(32'h554466);
    cyc(1, 0, 0);
    cyc(0, 1, 24'hA1B2C3);
    cyc(0, 1, 24'h0F1E2D);
    idle(50);
    cyc(1, 0, 0);
    cyc(0, 1, 24'h112233);
    cyc(0, 1, 24'h445566);
    wait_done(600, seen);
    check("t3_done_a", seen, 1);
    idle(2);
    check("t3_gap", led_dout, 0);
    @(posedge clkn);
    check("t3_restart", led_dout, 1);
    wait_done(600, seen);
    check("t3_done_b", seen, 1);
    idle(5);

    // 4: third frame while one is pending is dropped
    exp_q.push_back(32'h808080);
    exp_q.push_back(32'h020103);
    exp_q.push_back(32'hFFC0EE);
    exp_q.push_back(32'h341256);
    cyc(1, 0, 0);
    cyc(0, 1, 24'h808080);
    cyc(0, 1, 24'h010203);
    idle(10);
    cyc(1, 0, 0);
    cyc(0, 1, 24'hC0FFEE);
    cyc(0, 1, 24'h123456);
    idle(10);
    cyc(1, 0, 0);
    cyc(0, 1, 24'hDEADBE);
    cyc(0, 1, 24'hEF0000);
    check("t4_drop_pulse", frame_drop, 1);
    @(posedge clkn);
    check("t4_drop_single", frame_drop, 0);
    wait_done(600, seen);
    check("t4_done_a", seen, 1);
    wait_done(600, seen);
    check("t4_done_b", seen, 1);
    idle(5);

    // 5: surplus word ignored; incomplete frame never sent
    exp_q.push_back(32'hFF0000);
    exp_q.push_back(32'h0F0F0F);
    cyc(1, 0, 0);
    cyc(0, 1, 24'h00FF00);
    cyc(0, 1, 24'h0F0F0F);
    cyc(0, 1, 24'hFFFFFF);
    wait_done(600, seen);
    check("t5_done", seen, 1);
    idle(5);
    #1 r0 = rise_cnt;
    @(posedge clkn);
    cyc(1, 0, 0);
    cyc(0, 1, 24'h777777);
    cyc(1, 0, 0);
    wait_done(600, seen);
    check("t5_partial_not_sent", seen, 0);
    #1 check("t5_no_bits", rise_cnt - r0, 0);
    @(posedge clkn);

    // 6: word coincident with frame_start is dropped
    exp_q.push_back(32'h201030);
    exp_q.push_back(32'h5A5AA5);
    cyc(1, 1, 24'hAAAAAA);
    cyc(0, 1, 24'h102030);
    cyc(0, 1, 24'h5A5AA5);
    wait_done(600, seen);
    check("t6_done", seen, 1);
    idle(20);

    #1;
    check("queue_empty", exp_q.size(), 0);
    check("drop_count", drop_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
